// File: rtl/params_pkg.sv
// ----------------------------------------------------------------------------
// params_pkg
// Shared parameters and types for the AXI-Lite register slave.
//   ADDR_WIDTH  : system address width (the register port itself uses 10 bits)
//   DATA_WIDTH  : register / bus data width
//   REG_ADDR_W  : width of the byte address seen by the register port
//   REG_IDX_W   : width of the word index taken from addr[9:2]
//   axi_resp_e  : AXI response codes
//   wr_state_e  : write-channel FSM states
//   rd_state_e  : read-channel FSM states
// ----------------------------------------------------------------------------
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam int REG_ADDR_W = 10;
    localparam int REG_IDX_W  = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave_if
// AXI-Lite bus bundle between a master and the register slave.
//   AW channel : s_axi_lite_awvalid/awready, s_axi_lite_awaddr[9:0]
//   W  channel : s_axi_lite_wvalid/wready,   s_axi_lite_wdata[DATA_WIDTH-1:0]
//   B  channel : s_axi_lite_bvalid/bready,   s_axi_lite_bresp[1:0]
//   AR channel : s_axi_lite_arvalid/arready, s_axi_lite_araddr[9:0]
//   R  channel : s_axi_lite_rvalid/rready,   s_axi_lite_rdata, s_axi_lite_rresp[1:0]
// Modports: slave (the register block), master (the bus initiator).
// ----------------------------------------------------------------------------
interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
);

    logic                                s_axi_lite_awvalid;
    logic                                s_axi_lite_awready;
    logic [params_pkg::REG_ADDR_W-1:0]   s_axi_lite_awaddr;

    logic                                s_axi_lite_wvalid;
    logic                                s_axi_lite_wready;
    logic [DATA_WIDTH-1:0]               s_axi_lite_wdata;

    logic                                s_axi_lite_bvalid;
    logic                                s_axi_lite_bready;
    logic [1:0]                          s_axi_lite_bresp;

    logic                                s_axi_lite_arvalid;
    logic                                s_axi_lite_arready;
    logic [params_pkg::REG_ADDR_W-1:0]   s_axi_lite_araddr;

    logic                                s_axi_lite_rvalid;
    logic                                s_axi_lite_rready;
    logic [DATA_WIDTH-1:0]               s_axi_lite_rdata;
    logic [1:0]                          s_axi_lite_rresp;

    modport slave (
        input  s_axi_lite_awvalid, s_axi_lite_awaddr,
        input  s_axi_lite_wvalid,  s_axi_lite_wdata,
        input  s_axi_lite_bready,
        input  s_axi_lite_arvalid, s_axi_lite_araddr,
        input  s_axi_lite_rready,
        output s_axi_lite_awready, s_axi_lite_wready,
        output s_axi_lite_bvalid,  s_axi_lite_bresp,
        output s_axi_lite_arready,
        output s_axi_lite_rvalid,  s_axi_lite_rdata, s_axi_lite_rresp
    );

    modport master (
        output s_axi_lite_awvalid, s_axi_lite_awaddr,
        output s_axi_lite_wvalid,  s_axi_lite_wdata,
        output s_axi_lite_bready,
        output s_axi_lite_arvalid, s_axi_lite_araddr,
        output s_axi_lite_rready,
        input  s_axi_lite_awready, s_axi_lite_wready,
        input  s_axi_lite_bvalid,  s_axi_lite_bresp,
        input  s_axi_lite_arready,
        input  s_axi_lite_rvalid,  s_axi_lite_rdata, s_axi_lite_rresp
    );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
// AXI-Lite slave exposing NUM_REGS word registers from byte address 0x000.
// Word index is addr[9:2]; indices >= NUM_REGS are unmapped (writes dropped,
// reads return 0).
// Ports:
//   axi_aclk    : sole clock, rising edge
//   axi_resetn  : synchronous active-low reset
//   s_axi       : AXI-Lite slave modport (AW, W, B, AR, R channels)
//   reg_q       : flat view of all registers, register 0 in the LSBs
// Configuration macro:
//   AXIL_SLV_DECERR_EN : when defined, unmapped accesses answer DECERR;
//                        otherwise they answer OKAY.
// ----------------------------------------------------------------------------
module axi_lite_reg_slave
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 16
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    axi_lite_reg_slave_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

`ifdef AXIL_SLV_DECERR_EN
    localparam axi_resp_e UNMAPPED_RESP = DECERR;
`else
    localparam axi_resp_e UNMAPPED_RESP = OKAY;
`endif

    // Write channel state
    wr_state_e               wr_state_q;
    logic                    awready_q;
    logic                    wready_q;
    logic                    bvalid_q;
    axi_resp_e               bresp_q;
    logic [REG_ADDR_W-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // Read channel state
    rd_state_e               rd_state_q;
    logic                    arready_q;
    logic                    rvalid_q;
    axi_resp_e               rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    // Register file
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    wr_commit;
    logic [REG_ADDR_W-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [REG_IDX_W-1:0]    wr_idx;
    logic                    wr_mapped;
    axi_resp_e               wr_resp;
    logic [REG_IDX_W-1:0]    rd_idx;
    logic                    rd_mapped;
    logic [DATA_WIDTH-1:0]   rd_value;
    axi_resp_e               rd_resp;

    // Byte-lane bits and the system address width have no role here.
    logic                    unused_low_bits;
    logic [ADDR_WIDTH-1:0]   unused_sys_addr;

    assign unused_low_bits = ^{wr_addr[1:0], s_axi.s_axi_lite_araddr[1:0]};
    assign unused_sys_addr = '0;

    assign aw_hs = s_axi.s_axi_lite_awvalid & awready_q;
    assign w_hs  = s_axi.s_axi_lite_wvalid  & wready_q;
    assign ar_hs = s_axi.s_axi_lite_arvalid & arready_q;

    // Decide whether this edge completes an address/data pair, and pick the
    // address and data from either the held copy or the live bus depending
    // on which half arrived first.
    always_comb begin
        wr_commit = 1'b0;
        wr_addr   = s_axi.s_axi_lite_awaddr;
        wr_data   = s_axi.s_axi_lite_wdata;
        case (wr_state_q)
            W_IDLE: begin
                wr_commit = aw_hs & w_hs;
            end
            W_HAVE_ADDR: begin
                wr_commit = w_hs;
                wr_addr   = awaddr_q;
            end
            W_HAVE_DATA: begin
                wr_commit = aw_hs;
                wr_data   = wdata_q;
            end
            default: begin
                wr_commit = 1'b0;
            end
        endcase
    end

    assign wr_idx    = wr_addr[REG_ADDR_W-1:2];
    assign wr_mapped = ({{(32-REG_IDX_W){1'b0}}, wr_idx} < 32'(NUM_REGS));
    assign wr_resp   = wr_mapped ? OKAY : UNMAPPED_RESP;

    assign rd_idx    = s_axi.s_axi_lite_araddr[REG_ADDR_W-1:2];
    assign rd_mapped = ({{(32-REG_IDX_W){1'b0}}, rd_idx} < 32'(NUM_REGS));
    assign rd_resp   = rd_mapped ? OKAY : UNMAPPED_RESP;

    // Next register contents: only a committing, mapped write changes one
    // word; unmapped indices match no entry and fall through untouched.
    always_comb begin
        regs_d = regs_q;
        if (wr_commit && wr_mapped) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == REG_IDX_W'(i)) begin
                    regs_d[i] = wr_data;
                end
            end
        end
    end

    // Read mux works from the current register contents, so a read captured
    // on the same edge as a write to that register sees the old value.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == REG_IDX_W'(i)) begin
                rd_value = regs_q[i];
            end
        end
    end

    // Register storage
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write FSM. Readies are registered and only raised on the edge after
    // reset releases; the held half of a split transfer is kept in awaddr_q
    // or wdata_q until its partner arrives.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
        end else if (wr_commit) begin
            wr_state_q <= W_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_resp;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q   <= s_axi.s_axi_lite_awaddr;
                        wr_state_q <= W_HAVE_ADDR;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                    end else if (w_hs) begin
                        wdata_q    <= s_axi.s_axi_lite_wdata;
                        wr_state_q <= W_HAVE_DATA;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b0;
                    end else begin
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                W_HAVE_ADDR: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                end
                W_HAVE_DATA: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                end
                W_RESP: begin
                    if (s_axi.s_axi_lite_bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM. Data and response are captured at the AR handshake and held
    // steady until the master takes them.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q    <= rd_mapped ? rd_value : '0;
                        rresp_q    <= rd_resp;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.s_axi_lite_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi.s_axi_lite_awready = awready_q;
    assign s_axi.s_axi_lite_wready  = wready_q;
    assign s_axi.s_axi_lite_bvalid  = bvalid_q;
    assign s_axi.s_axi_lite_bresp   = bresp_q;
    assign s_axi.s_axi_lite_arready = arready_q;
    assign s_axi.s_axi_lite_rvalid  = rvalid_q;
    assign s_axi.s_axi_lite_rdata   = rdata_q;
    assign s_axi.s_axi_lite_rresp   = rresp_q;

    assign reg_q = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
// Directed bench for axi_lite_reg_slave: reset state, split and combined
// writes, backpressure on B, unmapped accesses, same-edge read/write to one
// register, and reset during a half-finished write.
// Honours AXIL_SLV_DECERR_EN for the expected unmapped response code.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;
    import params_pkg::*;

    localparam int NREGS = 16;
    localparam int DW    = 32;

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b11;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

    logic                  axi_aclk = 1'b0;
    logic                  axi_resetn;
    logic [NREGS*DW-1:0]   reg_q;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NREGS];

    always #5 axi_aclk = ~axi_aclk;

    axi_lite_reg_slave_if #(.DATA_WIDTH(DW)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NREGS)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .s_axi      (bus),
        .reg_q      (reg_q)
    );

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NREGS*DW-1:0] packModel();
        logic [NREGS*DW-1:0] p;
        for (int i = 0; i < NREGS; i++) begin
            p[i*DW +: DW] = model[i];
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkRegs(input string tag);
        logic [NREGS*DW-1:0] exp_flat;
        exp_flat = packModel();
        checks++;
        assert (reg_q === exp_flat) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, reg_q, exp_flat);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NREGS; i++) begin
            model[i] = '0;
        end
    endtask

    task automatic applyStimulus(input logic aw_v, input logic [9:0] aw_a,
                                 input logic w_v, input logic [31:0] w_d,
                                 input logic ar_v, input logic [9:0] ar_a,
                                 input logic b_r, input logic r_r);
        bus.s_axi_lite_awvalid = aw_v;
        bus.s_axi_lite_awaddr  = aw_a;
        bus.s_axi_lite_wvalid  = w_v;
        bus.s_axi_lite_wdata   = w_d;
        bus.s_axi_lite_arvalid = ar_v;
        bus.s_axi_lite_araddr  = ar_a;
        bus.s_axi_lite_bready  = b_r;
        bus.s_axi_lite_rready  = r_r;
    endtask

    // Full write with AW and W offered together; returns the B response.
    task automatic writeReg(input logic [9:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
        logic aw_done;
        logic w_done;
        logic aw_now;
        logic w_now;
        aw_done = 1'b0;
        w_done  = 1'b0;
        applyStimulus(1'b1, addr, 1'b1, data, 1'b0, '0, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_now = bus.s_axi_lite_awvalid && bus.s_axi_lite_awready;
            w_now  = bus.s_axi_lite_wvalid && bus.s_axi_lite_wready;
            tick();
            if (aw_now) begin
                bus.s_axi_lite_awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_now) begin
                bus.s_axi_lite_wvalid = 1'b0;
                w_done = 1'b1;
            end
        end
        if (!(aw_done && w_done)) checkOutput("write_handshake_timeout", 32'd0, 32'd1);
        for (int n = 0; n < 20 && !bus.s_axi_lite_bvalid; n++) tick();
        if (!bus.s_axi_lite_bvalid) checkOutput("bvalid_timeout", 32'd0, 32'd1);
        resp = bus.s_axi_lite_bresp;
        bus.s_axi_lite_bready = 1'b1;
        tick();
        bus.s_axi_lite_bready = 1'b0;
    endtask

    // Full read; returns data and response.
    task automatic readReg(input logic [9:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, addr, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !bus.s_axi_lite_arready; n++) tick();
        if (!bus.s_axi_lite_arready) checkOutput("arready_timeout", 32'd0, 32'd1);
        tick();
        bus.s_axi_lite_arvalid = 1'b0;
        for (int n = 0; n < 20 && !bus.s_axi_lite_rvalid; n++) tick();
        if (!bus.s_axi_lite_rvalid) checkOutput("rvalid_timeout", 32'd0, 32'd1);
        data = bus.s_axi_lite_rdata;
        resp = bus.s_axi_lite_rresp;
        bus.s_axi_lite_rready = 1'b1;
        tick();
        bus.s_axi_lite_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        // Reset state
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        axi_resetn = 1'b0;
        clearModel();
        repeat (3) tick();
        checkOutput("rst_awready", 32'(bus.s_axi_lite_awready), 32'd0);
        checkOutput("rst_wready",  32'(bus.s_axi_lite_wready),  32'd0);
        checkOutput("rst_arready", 32'(bus.s_axi_lite_arready), 32'd0);
        checkOutput("rst_bvalid",  32'(bus.s_axi_lite_bvalid),  32'd0);
        checkOutput("rst_rvalid",  32'(bus.s_axi_lite_rvalid),  32'd0);
        checkOutput("rst_rdata",   bus.s_axi_lite_rdata,        32'd0);
        checkRegs("rst_regs");

        // First edge out of reset raises every ready
        axi_resetn = 1'b1;
        tick();
        checkOutput("rel_awready", 32'(bus.s_axi_lite_awready), 32'd1);
        checkOutput("rel_wready",  32'(bus.s_axi_lite_wready),  32'd1);
        checkOutput("rel_arready", 32'(bus.s_axi_lite_arready), 32'd1);

        // AW then W on separate cycles to 0x018
        applyStimulus(1'b1, 10'h018, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("split_awready_low", 32'(bus.s_axi_lite_awready), 32'd0);
        checkOutput("split_wready_high", 32'(bus.s_axi_lite_wready),  32'd1);
        checkRegs("split_no_commit_yet");
        applyStimulus(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        model[6] = 32'hDEADBEEF;
        checkOutput("split_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd1);
        checkOutput("split_bresp",  32'(bus.s_axi_lite_bresp),  32'd0);
        checkRegs("split_reg6");
        bus.s_axi_lite_bready = 1'b1;
        tick();
        bus.s_axi_lite_bready = 1'b0;
        checkOutput("split_bvalid_drop", 32'(bus.s_axi_lite_bvalid),  32'd0);
        checkOutput("split_awready_ret", 32'(bus.s_axi_lite_awready), 32'd1);
        readReg(10'h018, d, r);
        checkOutput("rd018_data", d, 32'hDEADBEEF);
        checkOutput("rd018_resp", 32'(r), 32'd0);
        readReg(10'h01A, d, r);
        checkOutput("rd01A_lowbits_ignored", d, 32'hDEADBEEF);

        // W three cycles ahead of AW to 0x000
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("wfirst_wready_low",  32'(bus.s_axi_lite_wready),  32'd0);
        checkOutput("wfirst_awready_hi",  32'(bus.s_axi_lite_awready), 32'd1);
        repeat (2) tick();
        checkOutput("wfirst_no_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd0);
        checkRegs("wfirst_no_commit");
        applyStimulus(1'b1, 10'h000, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        model[0] = 32'h12345678;
        checkOutput("wfirst_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd1);
        checkRegs("wfirst_reg0");

        // Backpressure on B: a new write is offered but must wait
        applyStimulus(1'b1, 10'h008, 1'b1, 32'h00000055, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bhold_bvalid",  32'(bus.s_axi_lite_bvalid),  32'd1);
            checkOutput("bhold_awready", 32'(bus.s_axi_lite_awready), 32'd0);
            checkOutput("bhold_wready",  32'(bus.s_axi_lite_wready),  32'd0);
        end
        checkRegs("bhold_no_commit");
        applyStimulus(1'b1, 10'h008, 1'b1, 32'h00000055, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 10'h008, 1'b1, 32'h00000055, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("bdone_bvalid",  32'(bus.s_axi_lite_bvalid),  32'd0);
        checkOutput("bdone_awready", 32'(bus.s_axi_lite_awready), 32'd1);
        checkOutput("bdone_wready",  32'(bus.s_axi_lite_wready),  32'd1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        model[2] = 32'h00000055;
        checkOutput("next_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd1);
        checkRegs("next_reg2");
        bus.s_axi_lite_bready = 1'b1;
        tick();
        bus.s_axi_lite_bready = 1'b0;

        // Unmapped address 0x3FC
        readReg(10'h3FC, d, r);
        checkOutput("unmapped_rdata", d, 32'd0);
        checkOutput("unmapped_rresp", 32'(r), 32'(UNMAPPED_RESP));
        writeReg(10'h3FC, 32'hFFFFFFFF, r);
        checkOutput("unmapped_bresp", 32'(r), 32'(UNMAPPED_RESP));
        checkRegs("unmapped_write_dropped");

        // Same-edge write and read of register 1
        writeReg(10'h004, 32'h00000001, r);
        model[1] = 32'h00000001;
        checkRegs("reg1_seed");
        applyStimulus(1'b1, 10'h004, 1'b1, 32'hA5A5A5A5, 1'b1, 10'h004, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        model[1] = 32'hA5A5A5A5;
        checkOutput("same_edge_rvalid", 32'(bus.s_axi_lite_rvalid), 32'd1);
        checkOutput("same_edge_rdata",  bus.s_axi_lite_rdata,       32'h00000001);
        checkOutput("same_edge_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd1);
        checkRegs("same_edge_reg1");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        readReg(10'h004, d, r);
        checkOutput("same_edge_followup", d, 32'hA5A5A5A5);

        // Reset while holding an address and a pending read
        applyStimulus(1'b1, 10'h00C, 1'b0, '0, 1'b1, 10'h018, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("haveaddr_awready", 32'(bus.s_axi_lite_awready), 32'd0);
        checkOutput("haveaddr_wready",  32'(bus.s_axi_lite_wready),  32'd1);
        checkOutput("pending_rvalid",   32'(bus.s_axi_lite_rvalid),  32'd1);
        applyStimulus(1'b0, '0, 1'b1, 32'h00000077, 1'b0, '0, 1'b0, 1'b0);
        axi_resetn = 1'b0;
        tick();
        clearModel();
        checkOutput("midrst_awready", 32'(bus.s_axi_lite_awready), 32'd0);
        checkOutput("midrst_rvalid",  32'(bus.s_axi_lite_rvalid),  32'd0);
        checkOutput("midrst_bvalid",  32'(bus.s_axi_lite_bvalid),  32'd0);
        checkRegs("midrst_regs");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        axi_resetn = 1'b1;
        tick();
        checkOutput("post_awready", 32'(bus.s_axi_lite_awready), 32'd1);
        checkOutput("post_wready",  32'(bus.s_axi_lite_wready),  32'd1);
        checkOutput("post_arready", 32'(bus.s_axi_lite_arready), 32'd1);
        repeat (3) tick();
        checkOutput("post_bvalid", 32'(bus.s_axi_lite_bvalid), 32'd0);
        checkRegs("post_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
